// File: rtl/booth_seq_multiplier.sv
// rtl/booth_seq_multiplier.sv - sequential radix-4 Booth multiplier with start/done handshake
//
// Purpose: multiplies X by Y over WIDTH/2+1 iterations using one Booth recoder and one
// WIDTH+3-bit adder. Operands are treated as two's complement or unsigned according to
// signed_mode, which is sampled together with start.
//
// Parameters:
//   WIDTH        operand width, even and >= 4; product is 2*WIDTH bits
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        request pulse, sampled only while idle
//   signed_mode  1 = operands two's complement, 0 = unsigned (sampled with start)
//   X            multiplicand (sampled with start)
//   Y            multiplier (sampled with start)
//   busy         high while an operation is in flight
//   done         one-cycle pulse when Z is updated
//   Z            product, held until the next done
//
// Optional feature macro: BOOTH_ZERO_SKIP_EN
//   When defined, a start with X==0 or Y==0 completes on the sampling edge with Z=0
//   and never enters RUN.

module booth_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Z
);

  // Extended operand width: one bit for the unsigned/signed distinction plus one more
  // so the multiplier splits into a whole number of radix-4 digits.
  localparam int EW = WIDTH + 2;
  // Accumulator width: holds acc + 2*x without overflow.
  localparam int AW = WIDTH + 3;
  localparam int NITER = WIDTH / 2 + 1;
  localparam int CW = $clog2(NITER + 1);
  localparam logic [CW-1:0] N_LOAD = CW'(NITER);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [EW-1:0]   x_reg;
  logic [EW-1:0]   y_reg;
  logic            y_prev;
  logic [AW-1:0]   acc;
  logic [CW-1:0]   cnt;

  logic            load;
  logic            step;
  logic            finish;
  logic            zero_load;

  logic [EW-1:0]   x_ext;
  logic [EW-1:0]   y_ext;
  logic [2:0]      window;
  logic            pp_neg;
  logic            pp_two;
  logic            pp_zero;
  logic [AW-1:0]   x_wide;
  logic [AW-1:0]   pp;
  logic [AW-1:0]   sum;

  // ---------------------------------------------------------------------------
  // Operand extension
  // ---------------------------------------------------------------------------
  assign x_ext = signed_mode ? {{2{X[WIDTH-1]}}, X} : {2'b00, X};
  assign y_ext = signed_mode ? {{2{Y[WIDTH-1]}}, Y} : {2'b00, Y};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    zero_load  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef BOOTH_ZERO_SKIP_EN
          if ((X == '0) || (Y == '0)) begin
            zero_load = 1'b1;
          end else begin
            load       = 1'b1;
            state_next = RUN;
          end
`else
          load       = 1'b1;
          state_next = RUN;
`endif
        end
      end
      RUN: begin
        // The counter reaches zero after the last digit has been accumulated; the
        // following edge only publishes the result.
        if (cnt == '0) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else begin
          step = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Radix-4 Booth recoding of {y[i+1], y[i], y[i-1]}
  // ---------------------------------------------------------------------------
  assign window = {y_reg[1], y_reg[0], y_prev};

  always_comb begin
    pp_neg  = 1'b0;
    pp_two  = 1'b0;
    pp_zero = 1'b0;
    case (window)
      3'b000, 3'b111: pp_zero = 1'b1;
      3'b001, 3'b010: pp_neg  = 1'b0;
      3'b011:         pp_two  = 1'b1;
      3'b100: begin
        pp_two = 1'b1;
        pp_neg = 1'b1;
      end
      3'b101, 3'b110: pp_neg  = 1'b1;
      default:        pp_zero = 1'b1;
    endcase
  end

  assign x_wide = {x_reg[EW-1], x_reg};

  always_comb begin
    pp = '0;
    if (!pp_zero) begin
      pp = pp_two ? {x_wide[AW-2:0], 1'b0} : x_wide;
    end
  end

  assign sum = pp_neg ? (acc - pp) : (acc + pp);

  // ---------------------------------------------------------------------------
  // Datapath: the {acc, y_reg} pair shifts right by two each step. Product bits
  // enter y_reg from the top as the multiplier bits drain out of the bottom.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_reg  <= '0;
      y_reg  <= '0;
      y_prev <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      x_reg  <= x_ext;
      y_reg  <= y_ext;
      y_prev <= 1'b0;
      acc    <= '0;
      cnt    <= N_LOAD;
    end else if (step) begin
      acc    <= {sum[AW-1], sum[AW-1], sum[AW-1:2]};
      y_reg  <= {sum[1:0], y_reg[EW-1:2]};
      y_prev <= y_reg[1];
      cnt    <= cnt - CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Result and completion pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
      Z    <= '0;
    end else begin
      done <= finish | zero_load;
      if (finish) begin
        Z <= {acc[WIDTH-3:0], y_reg};
      end else if (zero_load) begin
        Z <= '0;
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb/tb_booth_seq_multiplier.sv - directed self-checking bench for booth_seq_multiplier

module tb_booth_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_mode;
  logic [31:0] x;
  logic [31:0] y;
  logic        busy;
  logic        done;
  logic [63:0] z;

  logic        start8;
  logic        sm8;
  logic [7:0]  x8;
  logic [7:0]  y8;
  logic        busy8;
  logic        done8;
  logic [15:0] z8;

  int tests;
  int fails;

  booth_seq_multiplier #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .X           (x),
    .Y           (y),
    .busy        (busy),
    .done        (done),
    .Z           (z)
  );

  booth_seq_multiplier #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .start       (start8),
    .signed_mode (sm8),
    .X           (x8),
    .Y           (y8),
    .busy        (busy8),
    .done        (done8),
    .Z           (z8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one start pulse; lat counts edges after the sampling edge up to the edge
  // that raised done (-1 on timeout).
  task automatic run_op(input logic sm, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat,
                        output logic busy_seen, output logic busy_at_done);
    @(negedge clk);
    signed_mode = sm;
    x = a;
    y = b;
    start = 1'b1;
    lat = -1;
    busy_seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (busy) busy_seen = 1'b1;
      if (done) begin
        lat = k;
        break;
      end
    end
    res = z;
    busy_at_done = busy;
  endtask

  logic [63:0] r;
  int          lat;
  int          lat2;
  logic        bseen;
  logic        bdone;
  logic        dseen;

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    start = 1'b0;
    signed_mode = 1'b0;
    x = '0;
    y = '0;
    start8 = 1'b0;
    sm8 = 1'b0;
    x8 = '0;
    y8 = '0;

    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_z", z, 64'(0));
    check("reset_z8", 64'(z8), 64'(0));
    rst = 1'b1;

    // Signed basic
    run_op(1'b1, 32'd15, -32'sd31, r, lat, bseen, bdone);
    check("signed_15x-31", r, -64'sd465);
    check("signed_latency", 64'(lat), 64'(18));
    check("busy_low_in_done", 64'(bdone), 64'(0));
    check("busy_seen", 64'(bseen), 64'(1));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'(0));

    run_op(1'b1, -32'sd12340, -32'sd54321, r, lat, bseen, bdone);
    check("signed_neg_neg", r, 64'd670321140);

    // Unsigned / signed extremes
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bseen, bdone);
    check("unsigned_max", r, 64'hFFFF_FFFE_0000_0001);
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bseen, bdone);
    check("signed_m1_m1", r, 64'd1);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, r, lat, bseen, bdone);
    check("signed_min_sq", r, 64'h4000_0000_0000_0000);
    run_op(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, r, lat, bseen, bdone);
    check("signed_min_max", r, 64'hC000_0000_8000_0000);

    // start re-pulsed mid-RUN with other operands is ignored
    @(negedge clk);
    signed_mode = 1'b1;
    x = 32'd7;
    y = 32'd9;
    start = 1'b1;
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k == 5) begin
        start = 1'b1;
        signed_mode = 1'b0;
        x = 32'd100;
        y = 32'd100;
      end
      if (k == 6) start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    check("repulse_result", z, 64'd63);
    check("repulse_latency", 64'(lat), 64'(18));

    // start held high through the done cycle starts a second operation
    @(negedge clk);
    signed_mode = 1'b1;
    x = 32'd3;
    y = -32'sd5;
    start = 1'b1;
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 0) begin
        x = -32'sd6;
        y = 32'd7;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    check("held_first_result", z, -64'sd15);
    check("held_first_latency", 64'(lat), 64'(18));
    lat2 = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k == 8) check("z_holds_during_run", z, -64'sd15);
      if (done) begin
        lat2 = k;
        break;
      end
    end
    check("held_second_result", z, -64'sd42);
    check("held_second_latency", 64'(lat2), 64'(18));

    repeat (4) @(negedge clk);
    check("z_holds_idle", z, -64'sd42);
    check("no_spurious_done", 64'(done), 64'(0));

    // Reset mid-operation
    @(negedge clk);
    signed_mode = 1'b1;
    x = 32'd1577;
    y = -32'sd40;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_z", z, 64'(0));
    @(negedge clk);
    rst = 1'b1;
    dseen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done) dseen = 1'b1;
    end
    check("abort_no_done", 64'(dseen), 64'(0));
    run_op(1'b1, 32'd1577, -32'sd40, r, lat, bseen, bdone);
    check("after_abort_result", r, -64'sd63080);
    check("after_abort_latency", 64'(lat), 64'(18));

    // Zero operand
    run_op(1'b1, 32'd0, -32'sd300, r, lat, bseen, bdone);
    check("zero_result", r, 64'(0));
`ifdef BOOTH_ZERO_SKIP_EN
    // done is raised by the sampling edge itself, one cycle after start went high
    check("zero_skip_latency", 64'(lat), 64'(0));
    check("zero_skip_busy", 64'(bseen), 64'(0));
`else
    check("zero_full_latency", 64'(lat), 64'(18));
`endif

    // WIDTH=8 signed corner
    @(negedge clk);
    sm8 = 1'b1;
    x8 = 8'h80;
    y8 = 8'h80;
    start8 = 1'b1;
    lat = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k == 0) start8 = 1'b0;
      if (done8) begin
        lat = k;
        break;
      end
    end
    check("w8_result", 64'(z8), 64'h4000);
    check("w8_latency", 64'(lat), 64'(6));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/booth_seq_multiplier.md
# booth_seq_multiplier

Parametrised sequential radix-4 Booth multiplier with a start/done handshake and a runtime signed/unsigned mode. It is the multi-cycle, area-lean member of the multiplier family. It trades latency for a single Booth recoder and adder instead of a full array, and serves datapaths where a product every few tens of cycles is sufficient.

## Interface

Parameters:
- WIDTH, 32: operand width. Must be even and ≥ 4. Product width is 2*WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request pulse. Sampled only while idle.
- signed_mode  in  1  1 = X, Y two's complement; 0 = unsigned. Sampled with start.
- X  in  WIDTH  multiplicand. Sampled with start.
- Y  in  WIDTH  multiplier. Sampled with start.
- busy  out  1  high while an operation is in flight.
- done  out  1  single-cycle pulse when Z is updated.
- Z  out  2*WIDTH  product. Holds its value until the next done.

## Operation

- State machine states: IDLE, RUN.
- IDLE, start=1:
  - Latch X and Y, each extended to WIDTH+2 bits: sign-extended if signed_mode=1, zero-extended if 0.
  - Clear the partial-product accumulator.
  - Load the iteration counter with N = WIDTH/2+1.
  - Go to RUN.
  - X, Y and signed_mode are ignored thereafter until the next IDLE.
- RUN, each cycle:
  - Recode the 3-bit window {y[i+1], y[i], y[i-1]} (y[-1]=0) into a digit in {-2,-1,0,+1,+2}.
  - Add the digit times the extended multiplicand to the accumulator, using a WIDTH+3-bit adder. Shift the accumulator/multiplier pair right by 2 arithmetically.
  - Decrement the counter.
- RUN, counter reaching 0:
  - Write the low 2*WIDTH bits of the result to Z.
  - Pulse done.
  - Return to IDLE.
- Result is exact modulo 2^(2*WIDTH) and cannot overflow for either mode.
- start while busy=1: ignored. No queueing, no error flag.

## Timing

- Reset (rst=0, asynchronous): state=IDLE, busy=0, done=0, Z=0, and all internal registers are cleared.
- Latency from the start-sampling edge to done=1 is N+1 = WIDTH/2+2 cycles, i.e. 18 for WIDTH=32.
- busy=1 from the edge that samples start through the edge that asserts done. busy=0 in the done cycle.
- done is high for exactly one cycle. Z is valid in that cycle and every cycle after it, until the next done.
- Back-to-back operation: start=1 in the done cycle is accepted. Throughput is one product per WIDTH/2+2 cycles.
- Reset asserted mid-RUN aborts the operation with no done. Z returns to 0.
- Reset released with start already high: start is sampled on the first rising edge after release.

## Configuration

- BOOTH_ZERO_SKIP_EN defined:
  - In IDLE with start=1 and X==0 or Y==0, skip RUN.
  - Write Z=0 and pulse done on the next edge (latency 1). busy stays 0 throughout.
- BOOTH_ZERO_SKIP_EN undefined:
  - Zero operands take the full WIDTH/2+2-cycle path like any other operand. Result is still 0.

## Test plan

All scenarios use WIDTH=32 unless stated.

- Signed basic: signed_mode=1, X=15, Y=-31, start one cycle.
  - Z=-465 with done exactly 18 cycles after start is sampled. Then signed_mode=1, X=-12340, Y=-54321 → Z=670321140.
- Unsigned extremes: signed_mode=0, X=Y=0xFFFFFFFF → Z=0xFFFFFFFE00000001.
  - Same operands with signed_mode=1 → Z=1.
- Signed corner: X=Y=-2^31 → Z=2^62.
  - X=-2^31, Y=2^31-1 → Z=-2^62+2^31.
- Handshake:
  - start re-pulsed mid-RUN with different X/Y: no effect on the result or timing.
  - start held high through the done cycle: second operation begins, and its done arrives 18 cycles later.
  - Z holds between operations.
- Reset mid-operation: drop rst 5 cycles into RUN (X=1577, Y=-40).
  - busy=0, done never pulses, Z=0 immediately, and no done appears afterwards.
  - A subsequent start gives Z=-63080.
- Zero operand: X=0, Y=-300.
  - With BOOTH_ZERO_SKIP_EN: done 1 cycle after start, Z=0, busy never high.
  - Without it: done after 18 cycles, Z=0.
  - Repeat with WIDTH=8, X=-128, Y=-128 (signed) → Z=16384 after 6 cycles.
